// File: rtl/pipe_hazard_unit.sv
// Data-hazard interlock for an in-order pipeline: tracks in-flight writers past
// decode, selects forwarding sources, raises stall/flush and counts both events.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int WB_DEPTH   = 2,
  parameter int LD_STAGE   = 2,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(WB_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  dec_valid_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_i,
  input  logic                  dec_rs1_used_i,
  input  logic                  dec_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  input  logic                  dec_wb_i,
  input  logic                  dec_is_ld_i,
  input  logic                  br_taken_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [SEL_W-1:0]      fwd_sel1_o,
  output logic [SEL_W-1:0]      fwd_sel2_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  logic [WB_DEPTH:1]     vld_q, wb_q, ld_q;
  logic [REG_ADDR_W-1:0] rd_q [WB_DEPTH:1];
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic                  haz1, haz2, issue;
  logic [SEL_W-1:0]      sel1, sel2;

  // Scan oldest to youngest so the youngest matching entry has the last word.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    sel1 = '0;
    sel2 = '0;
    for (int k = WB_DEPTH; k >= 1; k--) begin
      if (dec_rs1_used_i && vld_q[k] && wb_q[k] && rd_q[k] == dec_rs1_i) begin
        if (FWD_EN == 0 || (ld_q[k] && k < LD_STAGE)) begin
          haz1 = 1'b1;
          sel1 = '0;
        end else begin
          haz1 = 1'b0;
          sel1 = SEL_W'(k);
        end
      end
      if (dec_rs2_used_i && vld_q[k] && wb_q[k] && rd_q[k] == dec_rs2_i) begin
        if (FWD_EN == 0 || (ld_q[k] && k < LD_STAGE)) begin
          haz2 = 1'b1;
          sel2 = '0;
        end else begin
          haz2 = 1'b0;
          sel2 = SEL_W'(k);
        end
      end
    end
  end

  assign flush_o     = br_taken_i;
  assign stall_o     = ~reset_i & dec_valid_i & (haz1 | haz2) & ~br_taken_i;
  assign fwd_sel1_o  = (dec_valid_i && !reset_i) ? sel1 : '0;
  assign fwd_sel2_o  = (dec_valid_i && !reset_i) ? sel2 : '0;
  assign issue       = dec_valid_i & ~stall_o & ~br_taken_i;
  assign stall_cnt_d = (stall_o && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_o && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // Entry 1 always captures decode fields; only the valid bit marks a real issue.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_q       <= '0;
      wb_q        <= '0;
      ld_q        <= '0;
      for (int k = 1; k <= WB_DEPTH; k++) rd_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q[1] <= issue;
      wb_q[1]  <= dec_wb_i;
      ld_q[1]  <= dec_is_ld_i;
      rd_q[1]  <= dec_rd_i;
      for (int k = 2; k <= WB_DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        wb_q[k]  <= wb_q[k-1];
        ld_q[k]  <= ld_q[k-1];
        rd_q[k]  <= rd_q[k-1];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a forwarding instance and a stall-only 4-bit-counter
// instance share directed stimulus and are checked against an issue-history model.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, decValid, rs1Used, rs2Used, decWb, decLd, brTaken;
  logic [3:0] rs1, rs2, decRd;

  logic        stA, flA, stB, flB;
  logic [1:0]  s1A, s2A, s1B, s2B;
  logic [15:0] scA, fcA;
  logic [3:0]  scB, fcB;

  int total = 0;
  int bad   = 0;

  pipe_hazard_unit dutA (
    .clk_i(clk), .reset_i(reset), .dec_valid_i(decValid),
    .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_rs1_used_i(rs1Used), .dec_rs2_used_i(rs2Used),
    .dec_rd_i(decRd), .dec_wb_i(decWb), .dec_is_ld_i(decLd), .br_taken_i(brTaken),
    .stall_o(stA), .flush_o(flA), .fwd_sel1_o(s1A), .fwd_sel2_o(s2A),
    .stall_cnt_o(scA), .flush_cnt_o(fcA)
  );

  pipe_hazard_unit #(.FWD_EN(0), .CNT_W(4)) dutB (
    .clk_i(clk), .reset_i(reset), .dec_valid_i(decValid),
    .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_rs1_used_i(rs1Used), .dec_rs2_used_i(rs2Used),
    .dec_rd_i(decRd), .dec_wb_i(decWb), .dec_is_ld_i(decLd), .br_taken_i(brTaken),
    .stall_o(stB), .flush_o(flB), .fwd_sel1_o(s1B), .fwd_sel2_o(s2B),
    .stall_cnt_o(scB), .flush_cnt_o(fcB)
  );

  typedef struct {
    bit v;
    int rd;
    bit wb;
    bit ld;
  } rec_t;

  // Model: per instance, a history of what decode issued on each past cycle,
  // most recent first; element k-1 is the instruction k stages past decode.
  rec_t histA[$];
  rec_t histB[$];
  int   mscA = 0, mfcA = 0, mscB = 0, mfcB = 0;
  bit   started = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void srcEval(input rec_t h[$], input bit fwdEn, input bit used,
                                  input int idx, output bit haz, output int sel);
    haz = 1'b0;
    sel = 0;
    if (!used) return;
    for (int k = 1; k <= 2 && k <= h.size(); k++) begin
      if (h[k-1].v && h[k-1].wb && h[k-1].rd == idx) begin
        if (!fwdEn || (h[k-1].ld && k < 2)) haz = 1'b1;
        else sel = k;
        return;
      end
    end
  endfunction

  function automatic void evalModel(input rec_t h[$], input bit fwdEn,
                                    output bit st, output int e1, output int e2);
    bit h1, h2;
    int a, b;
    srcEval(h, fwdEn, rs1Used, int'(rs1), h1, a);
    srcEval(h, fwdEn, rs2Used, int'(rs2), h2, b);
    st = decValid && (h1 || h2) && !brTaken;
    e1 = decValid ? a : 0;
    e2 = decValid ? b : 0;
  endfunction

  always @(posedge clk) begin
    if (started) begin
      bit eA, eB;
      int x1, x2;
      rec_t r;
      if (reset) begin
        histA.delete(); histB.delete();
        mscA = 0; mfcA = 0; mscB = 0; mfcB = 0;
      end else begin
        evalModel(histA, 1'b1, eA, x1, x2);
        evalModel(histB, 1'b0, eB, x1, x2);
        if (eA && mscA < 65535) mscA++;
        if (brTaken && mfcA < 65535) mfcA++;
        if (eB && mscB < 15) mscB++;
        if (brTaken && mfcB < 15) mfcB++;
        r.rd = int'(decRd); r.wb = decWb; r.ld = decLd;
        r.v = decValid && !eA && !brTaken;
        histA.push_front(r);
        r.v = decValid && !eB && !brTaken;
        histB.push_front(r);
        if (histA.size() > 2) void'(histA.pop_back());
        if (histB.size() > 2) void'(histB.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit eA, eB;
      int a1, a2, b1, b2;
      if (reset) begin
        histA.delete(); histB.delete();
        mscA = 0; mfcA = 0; mscB = 0; mfcB = 0;
        eA = 0; eB = 0; a1 = 0; a2 = 0; b1 = 0; b2 = 0;
      end else begin
        evalModel(histA, 1'b1, eA, a1, a2);
        evalModel(histB, 1'b0, eB, b1, b2);
      end
      checkOutput("A.stall", stA, eA);
      checkOutput("A.flush", flA, brTaken);
      checkOutput("A.sel1", s1A, a1);
      checkOutput("A.sel2", s2A, a2);
      checkOutput("A.stallCnt", scA, mscA);
      checkOutput("A.flushCnt", fcA, mfcA);
      checkOutput("B.stall", stB, eB);
      checkOutput("B.flush", flB, brTaken);
      checkOutput("B.sel1", s1B, b1);
      checkOutput("B.sel2", s2B, b2);
      checkOutput("B.stallCnt", scB, mscB);
      checkOutput("B.flushCnt", fcB, mfcB);
    end
  end

  task automatic applyStimulus(input bit rst, input bit v, input int r1, input bit u1,
                               input int r2, input bit u2, input int rd, input bit wb,
                               input bit ld, input bit br);
    @(posedge clk);
    #1;
    reset    = rst;
    decValid = v;
    rs1      = 4'(r1);
    rs1Used  = u1;
    rs2      = 4'(r2);
    rs2Used  = u2;
    decRd    = 4'(rd);
    decWb    = wb;
    decLd    = ld;
    brTaken  = br;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic producer(input int rd, input bit ld);
    applyStimulus(0, 1, 0, 0, 0, 0, rd, 1, ld, 0);
  endtask

  task automatic use1(input int r);
    applyStimulus(0, 1, r, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic use2(input int r);
    applyStimulus(0, 1, 0, 0, r, 1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; decValid = 0; rs1 = 0; rs2 = 0; rs1Used = 0; rs2Used = 0;
    decRd = 0; decWb = 0; decLd = 0; brTaken = 0;
    started = 1'b1;

    // Reset state, with flush following br_taken while reset is held
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst.flush", flA, 1);
    checkOutput("rst.stall", stA, 0);
    checkOutput("rst.stallCnt", scA, 0);
    checkOutput("rst.flushCntB", fcB, 0);
    idle();

    // ALU result forwarded from stage 1, then stage 2
    doReset();
    producer(3, 0);
    use1(3);
    checkOutput("alu.stall", stA, 0);
    checkOutput("alu.sel1k1", s1A, 1);
    use1(3);
    checkOutput("alu.sel1k2", s1A, 2);
    idle(); idle();

    // Load-use: one stall cycle then forward from stage 2
    doReset();
    producer(5, 1);
    use2(5);
    checkOutput("ld.stall1", stA, 1);
    use2(5);
    checkOutput("ld.stall2", stA, 0);
    checkOutput("ld.sel2", s2A, 2);
    checkOutput("ld.stallCnt", scA, 1);
    idle(); idle();

    // Stall-only instance: two stall cycles, no forwarding
    doReset();
    producer(2, 0);
    use1(2);
    checkOutput("nofwd.stall1", stB, 1);
    checkOutput("nofwd.sel1", s1B, 0);
    use1(2);
    checkOutput("nofwd.stall2", stB, 1);
    use1(2);
    checkOutput("nofwd.stall3", stB, 0);
    checkOutput("nofwd.stallCnt", scB, 2);
    idle(); idle();

    // Two writers of r4 in flight: youngest wins
    doReset();
    producer(4, 0);
    producer(4, 0);
    applyStimulus(0, 1, 4, 1, 4, 1, 0, 0, 0, 0);
    checkOutput("young.sel1", s1A, 1);
    checkOutput("young.sel2", s2A, 1);
    idle(); idle();

    // Taken branch overrides a load-use stall and bubbles entry 1
    doReset();
    producer(5, 1);
    applyStimulus(0, 1, 0, 0, 5, 1, 7, 1, 0, 1);
    checkOutput("br.stall", stA, 0);
    checkOutput("br.flush", flA, 1);
    use1(7);
    checkOutput("br.bubble", s1A, 0);
    checkOutput("br.flushCnt", fcA, 1);
    idle(); idle();

    // Saturation of the 4-bit stall counter, then reset mid-stall
    doReset();
    for (int i = 0; i < 10; i++) begin
      producer(2, 0);
      use1(2); use1(2); use1(2);
    end
    checkOutput("sat.stallCntB", scB, 15);
    checkOutput("sat.stallCntA", scA, 0);
    producer(2, 0);
    use1(2);
    checkOutput("mid.stallB", stB, 1);
    applyStimulus(1, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("mid.rstStall", stB, 0);
    checkOutput("mid.rstCnt", scB, 0);
    use1(2);
    checkOutput("mid.afterRel", stB, 0);
    checkOutput("mid.afterSel", s1A, 0);
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter REG_ADDR_W, 4, register-index width.
REQ-002 Parameter WB_DEPTH, 2, number of stages after decode up to and including writeback, legal range 1..4.
REQ-003 Parameter LD_STAGE, 2, first post-decode stage (1..WB_DEPTH) in which load data is forwardable.
REQ-004 Parameter FWD_EN, 1, 1 = forwarding enabled, 0 = stall-only interlock.
REQ-005 Parameter CNT_W, 16, width of the performance counters.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 dec_valid  in  1  decode stage holds a real instruction.
REQ-009 dec_rs1 / dec_rs2  in  REG_ADDR_W each  source register indices.
REQ-010 dec_rs1_used / dec_rs2_used  in  1 each  source actually read.
REQ-011 dec_rd  in  REG_ADDR_W  destination index.
REQ-012 dec_wb  in  1  instruction writes dec_rd.
REQ-013 dec_is_ld  in  1  instruction is a load.
REQ-014 br_taken  in  1  branch resolved taken in stage 1 (execute).
REQ-015 stall  out  1  hold PC and fetch/decode latch, insert bubble into decode/execute latch.
REQ-016 flush  out  1  clear fetch/decode and decode/execute latches.
REQ-017 fwd_sel1 / fwd_sel2  out  clog2(WB_DEPTH+1) each  0 = register file, k = forward from stage k.
REQ-018 stall_cnt / flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-019 Tracker of WB_DEPTH entries {valid, rd, wb, is_ld}; entry k = instruction k stages past decode.
REQ-020 Issue = dec_valid & ~stall & ~flush; on issue entry 1 loads decode fields, else entry 1 loads a bubble (valid=0).
REQ-021 Entries k>1 load entry k-1 every cycle; entry WB_DEPTH is discarded after its writeback cycle.
REQ-022 Match on a source: source used, entry valid, entry wb=1, entry rd equals source index; register 0 is not special.
REQ-023 Per source, only the matching entry with smallest k (youngest) is considered.
REQ-024 FWD_EN=1: youngest match at k with is_ld=0 -> fwd_selN=k; with is_ld=1 and k>=LD_STAGE -> fwd_selN=k; with is_ld=1 and k<LD_STAGE -> hazard.
REQ-025 FWD_EN=0: any match -> hazard; fwd_selN held at 0.
REQ-026 No match -> fwd_selN=0.
REQ-027 stall = dec_valid & (hazard on rs1 or rs2) & ~br_taken; combinational, same cycle.
REQ-028 flush = br_taken; combinational; flush overrides stall and suppresses issue.
REQ-029 On flush the tracker still shifts and entry 1 loads a bubble; the branch already in entry 1 continues to shift.
REQ-030 Stall persists until the blocking entry advances out of the hazard window; no additional cycles.
REQ-031 stall_cnt increments on each cycle with stall=1; flush_cnt on each cycle with flush=1; both hold at all-ones.
REQ-032 Outputs depend only on tracker state and current inputs; when dec_valid=0, stall=0 and fwd_sel=0.

Reset
REQ-033 While reset is high: all tracker entries invalid, both counters 0, stall=0, fwd_sel1=fwd_sel2=0, flush=br_taken.
REQ-034 Reset asserted mid-stall clears the tracker immediately; the first cycle after release has no hazards.

Verification
REQ-035 Defaults: issue ADD r3 (wb); next cycle decode SUB rs1=r3 -> stall=0, fwd_sel1=1; one cycle later a user of r3 gets fwd_sel1=2.
REQ-036 Defaults: issue LD r5; next cycle ADD rs2=r5 -> stall=1 for exactly 1 cycle, then fwd_sel2=2, stall_cnt=1.
REQ-037 FWD_EN=0, WB_DEPTH=2: ADD r2 then user of r2 -> stall=1 for 2 cycles, fwd_sel=0 throughout, stall_cnt=2.
REQ-038 Back-to-back writes of r4 from stages 1 and 2 with a decode reader of r4 -> fwd_sel1=1, the youngest match.
REQ-039 Load-use stall with br_taken=1 in the same cycle -> stall=0, flush=1, entry 1 becomes a bubble, flush_cnt=1.
REQ-040 CNT_W=4, hazard held for 20 cycles -> stall_cnt saturates at 15; reset pulse mid-stall -> stall=0 and stall_cnt=0 immediately.
